// File: rtl/vx_decode_queue_if.sv
// Decode-queue port bundle: producer, consumer, flush and occupancy signals.
// master = environment around the queue, slave = the queue itself.
`ifndef NW_BITS
`define NW_BITS 2
`endif

interface vx_decode_queue_if #(
  parameter int DATAW    = 128,
  parameter int WID_BITS = `NW_BITS,
  parameter int DEPTH    = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                in_valid;
  logic [WID_BITS-1:0] in_wid;
  logic [DATAW-1:0]    in_data;
  logic                in_ready;
  logic                out_valid;
  logic [WID_BITS-1:0] out_wid;
  logic [DATAW-1:0]    out_data;
  logic                out_ready;
  logic                flush_valid;
  logic [WID_BITS-1:0] flush_wid;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                empty;

  modport master (
    output in_valid, in_wid, in_data, out_ready, flush_valid, flush_wid,
    input  in_ready, out_valid, out_wid, out_data, count, full, empty
  );

  modport slave (
    input  in_valid, in_wid, in_data, out_ready, flush_valid, flush_wid,
    output in_ready, out_valid, out_wid, out_data, count, full, empty
  );
endinterface

// File: rtl/vx_decode_queue.sv
// Circular decode queue with per-warp squash via per-entry kill bits.
// Optional macro DECODE_QUEUE_BYPASS_EN: 0-cycle pass-through when the queue is empty.
`ifndef NW_BITS
`define NW_BITS 2
`endif

module vx_decode_queue #(
  parameter int DATAW    = 128,
  parameter int DEPTH    = 4,
  parameter int WID_BITS = `NW_BITS
) (
  input  logic            clk,
  input  logic            reset,
  vx_decode_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATAW-1:0]    mem_data [DEPTH];
  logic [WID_BITS-1:0] mem_wid  [DEPTH];
  logic [DEPTH-1:0]    kill;
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    cnt;

  logic                full, empty, flush_hit_in, enq, deq;
  logic                out_valid;
  logic [WID_BITS-1:0] out_wid;
  logic [DATAW-1:0]    out_data;

  assign full         = (cnt == CNT_W'(DEPTH));
  assign empty        = (cnt == '0);
  assign flush_hit_in = q.flush_valid && (q.in_wid == q.flush_wid);

  always_comb begin
    out_valid = !empty && !kill[rd_ptr];
    out_wid   = mem_wid[rd_ptr];
    out_data  = mem_data[rd_ptr];
    // an entry squashed on arrival is accepted on the handshake but never written
    enq       = q.in_valid && !full && !flush_hit_in;
    // a killed head is retired without a handshake
    deq       = !empty && (kill[rd_ptr] || q.out_ready);
`ifdef DECODE_QUEUE_BYPASS_EN
    if (empty && q.in_valid && !flush_hit_in) begin
      out_valid = 1'b1;
      out_wid   = q.in_wid;
      out_data  = q.in_data;
      enq       = !q.out_ready;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      kill   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q.flush_valid && (mem_wid[i] == q.flush_wid))
          kill[i] <= 1'b1;
      end
      if (enq) begin
        kill[wr_ptr] <= 1'b0;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (deq)
        rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // payload storage carries no reset
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_data[wr_ptr] <= q.in_data;
      mem_wid[wr_ptr]  <= q.in_wid;
    end
  end

  assign q.in_ready  = !full;
  assign q.out_valid = out_valid;
  assign q.out_wid   = out_wid;
  assign q.out_data  = out_data;
  assign q.count     = cnt;
  assign q.full      = full;
  assign q.empty     = empty;
endmodule

// File: tb/tb_vx_decode_queue.sv
// Directed bench for vx_decode_queue (DEPTH=4, WID_BITS=2).
module tb_vx_decode_queue;
  localparam int DATAW = 128;
  localparam int WIDB  = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vx_decode_queue_if #(.DATAW(DATAW), .WID_BITS(WIDB), .DEPTH(DEPTH)) qif ();

  vx_decode_queue #(.DATAW(DATAW), .DEPTH(DEPTH), .WID_BITS(WIDB)) dut (
    .clk   (clk),
    .reset (rst),
    .q     (qif.slave)
  );

  function automatic logic [DATAW-1:0] pay(input int i);
    return {32'hDEAD_0000 + 32'(i), 32'h1234_5678, 32'(i * 7 + 3), 32'(i)};
  endfunction

  task automatic idle_inputs();
    qif.in_valid    = 1'b0;
    qif.in_wid      = '0;
    qif.in_data     = '0;
    qif.out_ready   = 1'b0;
    qif.flush_valid = 1'b0;
    qif.flush_wid   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (qif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", qif.out_valid); end
    checks++; if (qif.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", qif.empty); end
    checks++; if (qif.full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", qif.full); end
    checks++; if (qif.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", qif.count); end
    checks++; if (qif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", qif.in_ready); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      qif.in_valid = 1'b1; qif.in_wid = 2'(i); qif.in_data = pay(i); qif.out_ready = 1'b0;
    end
    @(negedge clk);
    qif.in_valid = 1'b0;
    #1;
    checks++; if (qif.full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b want 1", qif.full); end
    checks++; if (qif.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %0b want 0", qif.in_ready); end
    checks++; if (qif.count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", qif.count); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      qif.out_ready = 1'b1;
      // enqueue attempt while full and dequeuing must be refused
      qif.in_valid  = (i == 0);
      qif.in_wid    = 2'd3;
      qif.in_data   = pay(99);
      #1;
      checks++;
      if (qif.out_valid !== 1'b1 || qif.out_data !== pay(i)) begin
        errors++; $display("FAIL fill_order[%0d] got v=%0b d=%h want v=1 d=%h", i, qif.out_valid, qif.out_data, pay(i));
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (qif.empty !== 1'b1) begin errors++; $display("FAIL fill_drain_empty got %0b want 1", qif.empty); end
    checks++; if (qif.count !== 3'd0) begin errors++; $display("FAIL fill_drain_count got %0d want 0", qif.count); end
  endtask

  task automatic test_latency();
    @(negedge clk);
    qif.in_valid = 1'b1; qif.in_wid = 2'd1; qif.in_data = pay(50); qif.out_ready = 1'b0;
    #1;
`ifdef DECODE_QUEUE_BYPASS_EN
    checks++; if (qif.out_valid !== 1'b1 || qif.out_data !== pay(50)) begin errors++; $display("FAIL bypass_hold got v=%0b d=%h want v=1 d=%h", qif.out_valid, qif.out_data, pay(50)); end
`else
    checks++; if (qif.out_valid !== 1'b0) begin errors++; $display("FAIL latency_same_cycle got %0b want 0", qif.out_valid); end
`endif
    @(negedge clk);
    qif.in_valid = 1'b0;
    #1;
    checks++; if (qif.out_valid !== 1'b1 || qif.out_data !== pay(50) || qif.out_wid !== 2'd1) begin
      errors++; $display("FAIL latency_next_cycle got v=%0b w=%0d d=%h want v=1 w=1 d=%h", qif.out_valid, qif.out_wid, qif.out_data, pay(50));
    end
    @(negedge clk);
    #1;
    checks++; if (qif.out_data !== pay(50) || qif.out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got v=%0b d=%h want v=1 d=%h", qif.out_valid, qif.out_data, pay(50)); end
    @(negedge clk);
    qif.out_ready = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (qif.empty !== 1'b1) begin errors++; $display("FAIL latency_drain_empty got %0b want 1", qif.empty); end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      qif.in_valid  = (c < 10);
      qif.in_wid    = 2'(c);
      qif.in_data   = pay(100 + c);
      qif.out_ready = 1'b1;
      #1;
      if (qif.out_valid === 1'b1) begin
        checks++;
        if (qif.out_data !== pay(100 + got)) begin
          errors++; $display("FAIL wrap_order[%0d] got %h want %h", got, qif.out_data, pay(100 + got));
        end
        got++;
      end
      if (qif.count > 3'd1) begin
        errors++; $display("FAIL wrap_count got %0d want <=1", qif.count);
      end
    end
    idle_inputs();
    checks++; if (got !== 10) begin errors++; $display("FAIL wrap_total got %0d want 10", got); end
    checks++; if (qif.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %0b want 1", qif.empty); end
  endtask

  task automatic test_flush();
    logic [WIDB-1:0] wids [4];
    logic [WIDB-1:0] exp_w [2];
    int idx = 0;
    wids[0] = 2'd0; wids[1] = 2'd1; wids[2] = 2'd0; wids[3] = 2'd2;
    exp_w[0] = 2'd1; exp_w[1] = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      qif.in_valid = 1'b1; qif.in_wid = wids[i]; qif.in_data = pay(200 + i); qif.out_ready = 1'b0;
    end
    @(negedge clk);
    qif.in_valid = 1'b0; qif.flush_valid = 1'b1; qif.flush_wid = 2'd0;
    #1;
    checks++; if (qif.out_valid !== 1'b1 || qif.out_wid !== 2'd0) begin errors++; $display("FAIL flush_same_cycle got v=%0b w=%0d want v=1 w=0", qif.out_valid, qif.out_wid); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      qif.flush_valid = 1'b0; qif.out_ready = 1'b1;
      #1;
      if (c == 0) begin
        checks++; if (qif.count !== 3'd4) begin errors++; $display("FAIL flush_count_killed got %0d want 4", qif.count); end
      end
      if (qif.out_valid === 1'b1) begin
        checks++;
        if (idx > 1 || qif.out_wid !== exp_w[idx[0]]) begin
          errors++; $display("FAIL flush_out[%0d] got wid %0d want %0d", idx, qif.out_wid, (idx > 1) ? -1 : int'(exp_w[idx[0]]));
        end
        idx++;
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (idx !== 2) begin errors++; $display("FAIL flush_total got %0d want 2", idx); end
    checks++; if (qif.count !== 3'd0) begin errors++; $display("FAIL flush_count_end got %0d want 0", qif.count); end
  endtask

  task automatic test_enq_flush();
    @(negedge clk);
    qif.in_valid = 1'b1; qif.in_wid = 2'd3; qif.in_data = pay(300);
    qif.flush_valid = 1'b1; qif.flush_wid = 2'd3; qif.out_ready = 1'b1;
    #1;
    checks++; if (qif.in_ready !== 1'b1) begin errors++; $display("FAIL enqflush_in_ready got %0b want 1", qif.in_ready); end
    checks++; if (qif.out_valid !== 1'b0) begin errors++; $display("FAIL enqflush_same_out got %0b want 0", qif.out_valid); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (qif.out_valid !== 1'b0) begin errors++; $display("FAIL enqflush_next_out got %0b want 0", qif.out_valid); end
    checks++; if (qif.count !== 3'd0) begin errors++; $display("FAIL enqflush_count got %0d want 0", qif.count); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      qif.in_valid = 1'b1; qif.in_wid = 2'(i); qif.in_data = pay(400 + i); qif.out_ready = 1'b0;
    end
    @(negedge clk);
    qif.in_valid = 1'b0;
    #1;
    checks++; if (qif.count !== 3'd3) begin errors++; $display("FAIL midreset_pre_count got %0d want 3", qif.count); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (qif.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %0b want 0", qif.out_valid); end
    checks++; if (qif.count !== 3'd0) begin errors++; $display("FAIL midreset_count got %0d want 0", qif.count); end
    checks++; if (qif.empty !== 1'b1) begin errors++; $display("FAIL midreset_empty got %0b want 1", qif.empty); end
  endtask

`ifdef DECODE_QUEUE_BYPASS_EN
  task automatic test_bypass();
    @(negedge clk);
    qif.in_valid = 1'b1; qif.in_wid = 2'd2; qif.in_data = pay(500); qif.out_ready = 1'b1;
    #1;
    checks++; if (qif.out_valid !== 1'b1 || qif.out_data !== pay(500) || qif.out_wid !== 2'd2) begin
      errors++; $display("FAIL bypass_out got v=%0b w=%0d d=%h want v=1 w=2 d=%h", qif.out_valid, qif.out_wid, qif.out_data, pay(500));
    end
    checks++; if (qif.count !== 3'd0) begin errors++; $display("FAIL bypass_count_same got %0d want 0", qif.count); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (qif.count !== 3'd0 || qif.empty !== 1'b1) begin errors++; $display("FAIL bypass_count_next got %0d want 0", qif.count); end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_fill();
    test_latency();
    test_back_to_back();
    test_flush();
    test_enq_flush();
    test_reset_mid();
`ifdef DECODE_QUEUE_BYPASS_EN
    test_bypass();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
